// File: rtl/adder_rs_scheduler_if.sv
// adder_rs_scheduler_if: issue and status bus between the instruction queue and the adder RS scheduler
interface adder_rs_scheduler_if #(parameter int NUM_RS = 6);
    logic              issue;
    logic [5:0]        operation;
    logic [NUM_RS-1:0] A_tag;
    logic [NUM_RS-1:0] B_tag;
    logic              adder_available;
    logic [NUM_RS-1:0] adder_RS_available;
    logic              issue_error;
    logic [NUM_RS-1:0] RS_issued;
    logic [NUM_RS-1:0] RS_executing_adder;
    logic [NUM_RS-1:0] RS_finished;
    logic              adder_start;
    logic [5:0]        adder_op;

    modport master (
        output issue, operation, A_tag, B_tag,
        input  adder_available, adder_RS_available, issue_error, RS_issued,
               RS_executing_adder, RS_finished, adder_start, adder_op
    );
    modport slave (
        input  issue, operation, A_tag, B_tag,
        output adder_available, adder_RS_available, issue_error, RS_issued,
               RS_executing_adder, RS_finished, adder_start, adder_op
    );
endinterface

// File: rtl/adder_rs_scheduler.sv
// adder_rs_scheduler: adder reservation-station allocation, tag wakeup and dispatch FSM.
// Define RS_ROUND_ROBIN_EN for a round-robin dispatch arbiter; default is lowest-ready-index.
module adder_rs_scheduler #(
    parameter int NUM_RS        = 6,
    parameter int ADDER_LATENCY = 2
) (
    input logic                 clock,
    input logic                 reset_n,
    adder_rs_scheduler_if.slave bus
);
    localparam int CW = ADDER_LATENCY > 1 ? $clog2(ADDER_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [NUM_RS-1:0] busy, cur, cur_n, ready, sel;
    logic [5:0]        op [NUM_RS];
    logic [NUM_RS-1:0] qj [NUM_RS];
    logic [NUM_RS-1:0] qk [NUM_RS];
    logic [5:0]        op_nxt;
    logic              dispatch, alloc;

    function automatic logic [NUM_RS-1:0] low1(input logic [NUM_RS-1:0] x);
        return x & (~x + NUM_RS'(1));
    endfunction

    assign bus.adder_available    = ~busy != '0;
    assign bus.adder_RS_available = low1(~busy);
    assign alloc                  = bus.issue && bus.adder_available;

    // cur stays set through DONE so the finishing RS is never re-picked
    always_comb begin
        ready = '0;
        for (int i = 0; i < NUM_RS; i++)
            ready[i] = busy[i] && qj[i] == '0 && qk[i] == '0 && !cur[i];
    end

`ifdef RS_ROUND_ROBIN_EN
    logic [NUM_RS-1:0] last_oh, upper;
    assign upper = ready & ~((last_oh << 1) - NUM_RS'(1));
    assign sel   = upper != '0 ? low1(upper) : low1(ready);

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) last_oh <= NUM_RS'(1) << (NUM_RS - 1);
        else if (dispatch) last_oh <= sel;
`else
    assign sel = low1(ready);
`endif

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        cur_n    = cur;
        dispatch = 1'b0;
        if (state == EXEC) begin
            state_n = cnt == '0 ? DONE : EXEC;
            cnt_n   = cnt == '0 ? cnt : cnt - 1'b1;
        end else if (ready != '0) begin
            state_n  = EXEC;
            cnt_n    = CW'(ADDER_LATENCY - 1);
            cur_n    = sel;
            dispatch = 1'b1;
        end else begin
            state_n = IDLE;
            cur_n   = '0;
        end
    end

    always_comb begin
        op_nxt = '0;
        for (int i = 0; i < NUM_RS; i++)
            if (cur_n[i]) op_nxt = op[i];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                  <= IDLE;
            cnt                    <= '0;
            cur                    <= '0;
            busy                   <= '0;
            bus.RS_issued          <= '0;
            bus.issue_error        <= 1'b0;
            bus.RS_executing_adder <= '0;
            bus.RS_finished        <= '0;
            bus.adder_start        <= 1'b0;
            bus.adder_op           <= '0;
            for (int i = 0; i < NUM_RS; i++) begin
                op[i] <= '0;
                qj[i] <= '0;
                qk[i] <= '0;
            end
        end else begin
            state                  <= state_n;
            cnt                    <= cnt_n;
            cur                    <= cur_n;
            busy                   <= (busy | (alloc ? bus.adder_RS_available : '0)) & ~bus.RS_finished;
            bus.RS_issued          <= alloc ? bus.adder_RS_available : '0;
            bus.issue_error        <= bus.issue && !bus.adder_available;
            bus.RS_executing_adder <= state_n == EXEC ? cur_n : '0;
            bus.RS_finished        <= state_n == DONE ? cur : '0;
            bus.adder_start        <= dispatch;
            bus.adder_op           <= state_n == EXEC ? op_nxt : '0;
            // a tag matching the broadcast this cycle is captured as already available
            for (int i = 0; i < NUM_RS; i++) begin
                if (alloc && bus.adder_RS_available[i]) begin
                    op[i] <= bus.operation;
                    qj[i] <= bus.A_tag == bus.RS_finished ? '0 : bus.A_tag;
                    qk[i] <= bus.B_tag == bus.RS_finished ? '0 : bus.B_tag;
                end else if (bus.RS_finished != '0) begin
                    if (qj[i] == bus.RS_finished) qj[i] <= '0;
                    if (qk[i] == bus.RS_finished) qk[i] <= '0;
                end
            end
        end
    end
endmodule
